// File: rtl/enc_4_2_rr.sv
// enc_4_2_rr: registered 4-to-2 encoder with round-robin priority and a
// valid/ack handshake. Requests are active-low one-cold lines; a grant is
// sticky in HOLD until the consumer acknowledges it.
module enc_4_2_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_n,
  input  logic [3:0] req_n,
  input  logic       ack,
  output logic [1:0] sel,
  output logic       valid,
  output logic       multi
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_sel;
  logic             r_valid;
  logic             r_multi;

  logic [IDX_W-1:0] w_search_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_grant;
  logic             w_multi;
  logic             w_accept;

  // First active-low request at or after ptr, walking upward modulo 4.
  function automatic logic [IDX_W-1:0] f_search(input logic [IDX_W-1:0] ptr,
                                                input logic [NREQ-1:0]  rq_n);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             hit;
    res = ptr;
    hit = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!hit && !rq_n[idx]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  // An accepted grant advances the pointer in the same edge that reloads.
  assign w_accept     = (r_state == HOLD) && ack;
  assign w_search_ptr = w_accept ? (r_sel + IDX_W'(1)) : r_ptr;
  assign w_idx        = f_search(w_search_ptr, req_n);
  assign w_grant      = !enable_n && (req_n != 4'b1111);
  assign w_multi      = ($countones(~req_n) >= 2);

  // FSM, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_sel   <= w_idx;
            r_multi <= w_multi;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (ack) begin
            r_ptr <= w_search_ptr;
            if (w_grant) begin
              r_sel   <= w_idx;
              r_multi <= w_multi;
              r_valid <= 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sel   = r_sel;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule

// File: tb/tb_enc_4_2_rr.sv
// Directed bench for enc_4_2_rr with hand-computed expectations.
module tb_enc_4_2_rr;

  logic       clk;
  logic       rst;
  logic       enable_n;
  logic [3:0] req_n;
  logic       ack;
  logic [1:0] sel;
  logic       valid;
  logic       multi;

  int n_checks;
  int n_errors;

  enc_4_2_rr dut (
    .clk      (clk),
    .rst      (rst),
    .enable_n (enable_n),
    .req_n    (req_n),
    .ack      (ack),
    .sel      (sel),
    .valid    (valid),
    .multi    (multi)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expectation.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int e_sel, input int e_valid,
                           input int e_multi);
    check({tag, ".sel"},   int'(sel),   e_sel);
    check({tag, ".valid"}, int'(valid), e_valid);
    check({tag, ".multi"}, int'(multi), e_multi);
  endtask

  initial begin
    int exp_rr [5];
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    enable_n = 1'b0;
    req_n    = 4'b0000;
    ack      = 1'b0;

    // Reset dominates active requests.
    tick();
    tick();
    check_out("reset", 0, 0, 0);

    // Disabled: no grant.
    rst      = 1'b0;
    enable_n = 1'b1;
    tick();
    tick();
    check("idle_dis.valid", int'(valid), 0);

    // Single request on line 2.
    enable_n = 1'b0;
    req_n    = 4'b1011;
    tick();
    check_out("single", 2, 1, 0);
    req_n = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("hold", 2, 1, 0);
    end
    ack = 1'b1;
    tick();
    check("ack_release.valid", int'(valid), 0);
    check("ack_release.sel",   int'(sel),   2);
    ack = 1'b0;

    // Round robin from reset with all requesting and ack held.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    enable_n = 1'b0;
    req_n    = 4'b0000;
    ack      = 1'b1;
    exp_rr   = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rr%0d", i), exp_rr[i], 1, 1);
    end
    tick();
    check_out("rr5", 1, 1, 1);
    tick();
    check_out("rr6", 2, 1, 1);
    tick();
    check_out("rr7", 3, 1, 1);

    // Accept index 3 (ptr wraps to 0), only line 1 requesting.
    req_n = 4'b1101;
    tick();
    check_out("skip", 1, 1, 0);
    // Accept index 1 (ptr=2), only line 0: search wraps past 3.
    req_n = 4'b1110;
    tick();
    check_out("wrap", 0, 1, 0);
    req_n = 4'b1111;
    tick();
    check("drain.valid", int'(valid), 0);
    ack = 1'b0;

    // Enable gating; ptr is now 1.
    enable_n = 1'b1;
    req_n    = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gated.valid", int'(valid), 0);
    end
    enable_n = 1'b0;
    tick();
    check_out("enabled", 3, 1, 0);
    enable_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("hold_dis", 3, 1, 0);
    end
    ack = 1'b1;
    tick();
    check("ack_dis.valid", int'(valid), 0);
    ack = 1'b0;

    // Move ptr away from 0, then reset mid-HOLD.
    enable_n = 1'b0;
    req_n    = 4'b1011;
    tick();
    check_out("pre_rst", 2, 1, 0);
    ack = 1'b1;
    tick();
    check_out("pre_rst_ack", 2, 1, 0);
    ack = 1'b0;
    rst = 1'b1;
    tick();
    check_out("mid_rst", 0, 0, 0);
    rst   = 1'b0;
    req_n = 4'b0000;
    tick();
    check_out("post_rst", 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
